// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//
// Merges the core's instruction-fetch and load/store SRAM ports onto one
// shared single-port memory bus with an address/data handshake. A pending
// load/store is always served before the fetch. The arbiter holds the
// pipeline through stallreq until both have completed. Read data comes back
// on the core's existing rdata ports.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   inst_sram_en/wen/addr/wdata   fetch request from the core (wen/wdata unused: fetches are reads)
//   inst_sram_rdata               fetched word, registered
//   data_sram_en/wen/addr/wdata   load/store request from the core (wen == 0 means load)
//   data_sram_rdata               loaded word, registered
//   stallreq                      pipeline hold request to CTRL (combinational)
//   mem_req/wr/wstrb/addr/wdata   shared-bus request, registered
//   mem_addr_ok                   bus accepted the request this cycle
//   mem_data_ok, mem_rdata        bus finished the transaction; read data valid

module cpu_mem_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,

    output logic        stallreq,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        D_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state;

    logic        inst_en_q;
    logic [31:0] inst_addr_q;
    logic [3:0]  inst_wen_q;
    logic [31:0] inst_wdata_q;

    logic        data_en_q;
    logic [31:0] data_addr_q;
    logic [3:0]  data_wen_q;
    logic [31:0] data_wdata_q;

    // Sequencer: one transaction outstanding at a time, data before fetch.
    // Bus outputs are loaded on the transition into a REQ state so they are
    // stable for the whole time the request is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            inst_en_q       <= 1'b0;
            inst_addr_q     <= 32'h0;
            inst_wen_q      <= 4'h0;
            inst_wdata_q    <= 32'h0;
            data_en_q       <= 1'b0;
            data_addr_q     <= 32'h0;
            data_wen_q      <= 4'h0;
            data_wdata_q    <= 32'h0;
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            mem_req         <= 1'b0;
            mem_wr          <= 1'b0;
            mem_wstrb       <= 4'h0;
            mem_addr        <= 32'h0;
            mem_wdata       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_sram_en || data_sram_en) begin
                        inst_en_q    <= inst_sram_en;
                        inst_addr_q  <= inst_sram_addr;
                        inst_wen_q   <= inst_sram_wen;
                        inst_wdata_q <= inst_sram_wdata;
                        data_en_q    <= data_sram_en;
                        data_addr_q  <= data_sram_addr;
                        data_wen_q   <= data_sram_wen;
                        data_wdata_q <= data_sram_wdata;
                        mem_req      <= 1'b1;
                        if (data_sram_en) begin
                            state     <= D_REQ;
                            mem_wr    <= |data_sram_wen;
                            mem_wstrb <= data_sram_wen;
                            mem_addr  <= data_sram_addr;
                            mem_wdata <= data_sram_wdata;
                        end else begin
                            // Fetches are always reads: strobes masked to zero.
                            state     <= I_REQ;
                            mem_wr    <= 1'b0;
                            mem_wstrb <= inst_sram_wen & 4'b0000;
                            mem_addr  <= inst_sram_addr;
                            mem_wdata <= inst_sram_wdata;
                        end
                    end
                end

                D_REQ: begin
                    if (mem_addr_ok) begin
                        state   <= D_WAIT;
                        mem_req <= 1'b0;
                    end
                end

                D_WAIT: begin
                    if (mem_data_ok) begin
                        // Stores leave the load-data register untouched.
                        if (data_wen_q == 4'h0) begin
                            data_sram_rdata <= mem_rdata;
                        end
                        if (inst_en_q) begin
                            state     <= I_REQ;
                            mem_req   <= 1'b1;
                            mem_wr    <= 1'b0;
                            mem_wstrb <= inst_wen_q & 4'b0000;
                            mem_addr  <= inst_addr_q;
                            mem_wdata <= inst_wdata_q;
                        end else begin
                            state <= DONE;
                        end
                    end
                end

                I_REQ: begin
                    if (mem_addr_ok) begin
                        state   <= I_WAIT;
                        mem_req <= 1'b0;
                    end
                end

                I_WAIT: begin
                    if (mem_data_ok) begin
                        inst_sram_rdata <= mem_rdata;
                        state           <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // The stall must already be high in the IDLE cycle that sees a request,
    // so it is decoded from the live request inputs rather than registered.
    // DONE releases the pipeline for exactly one cycle.
    always_comb begin
        stallreq = 1'b0;
        if (!rst) begin
            case (state)
                D_REQ, D_WAIT, I_REQ, I_WAIT: stallreq = 1'b1;
                IDLE:                         stallreq = inst_sram_en || data_sram_en;
                default:                      stallreq = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Sits directly downstream of the core's instruction and data SRAM ports and merges them onto one shared single-port memory bus with an address/data handshake. Each cycle, it accepts the core's fetch request and optional load/store request. It serves them one at a time, data first, and raises a stall request to the core's CTRL until both have completed. It returns the read data on the core's existing `inst_sram_rdata` and `data_sram_rdata` inputs, with the one-cycle-after-request timing the pipeline already expects.

## Interface
- Parameters: none; all widths are fixed at 32-bit address/data and 4-bit byte strobes.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_sram_en` in 1: fetch request from the core.
- `inst_sram_wen` in 4: ignored; fetches are always reads.
- `inst_sram_addr` in 32: fetch address.
- `inst_sram_wdata` in 32: ignored.
- `inst_sram_rdata` out 32: fetched word, registered.
- `data_sram_en` in 1: load/store request from the core.
- `data_sram_wen` in 4: byte write strobes; 0 means load.
- `data_sram_addr` in 32: load/store address.
- `data_sram_wdata` in 32: store data.
- `data_sram_rdata` out 32: loaded word, registered.
- `stallreq` out 1: holds the whole pipeline while high; routed to CTRL.
- `mem_req` out 1: request valid on the shared bus.
- `mem_wr` out 1: 1 = write, 0 = read.
- `mem_wstrb` out 4: byte strobes (4'b0000 for reads).
- `mem_addr` out 32: shared-bus address.
- `mem_wdata` out 32: shared-bus write data.
- `mem_addr_ok` in 1: request accepted this cycle (handshake when `mem_req && mem_addr_ok`).
- `mem_data_ok` in 1: current transaction finished; `mem_rdata` is valid this cycle.
- `mem_rdata` in 32: read data from the shared bus.

## Operation
- States:
  - IDLE
  - D_REQ: data request presented
  - D_WAIT: data accepted, waiting for completion
  - I_REQ: fetch request presented
  - I_WAIT: fetch accepted, waiting for completion
  - DONE
- Request latching in IDLE: when `inst_sram_en || data_sram_en`, latch the following, each captured for inst and data separately:
  - en
  - addr
  - wen
  - wdata
- IDLE next state: D_REQ if data en; else I_REQ if inst en; else stay in IDLE.
- D_REQ / I_REQ:
  - `mem_req`=1.
  - `mem_addr`, `mem_wr`, `mem_wstrb`, `mem_wdata` come from the latched request; `mem_wr` = |wen.
  - For fetches: `mem_wr`=0 and `mem_wstrb`=0.
  - On `mem_addr_ok`, go to the matching WAIT state; otherwise hold, with all bus outputs stable.
- D_WAIT: on `mem_data_ok`:
  - Capture `mem_rdata` into `data_sram_rdata` only if the request was a load; stores leave `data_sram_rdata` unchanged.
  - Next state: I_REQ if inst en was latched, else DONE.
- I_WAIT: on `mem_data_ok`, capture `mem_rdata` into `inst_sram_rdata`, then go to DONE.
- DONE: go to IDLE unconditionally.
- Only one transaction is outstanding at a time. `mem_req` is 0 in every state other than D_REQ and I_REQ.
- `mem_data_ok` arriving outside D_WAIT/I_WAIT is ignored.
- `stallreq` is combinational:
  - 1 in D_REQ, D_WAIT, I_REQ and I_WAIT.
  - 1 in IDLE when `inst_sram_en || data_sram_en`.
  - 0 in DONE.
  - 0 while `rst`.
- The rdata registers hold their value until the next capture. Because no capture can occur earlier than 2 cycles after DONE, the core reads stable data in the cycle after DONE.

## Timing
- Reset values:
  - state IDLE
  - all latched requests 0
  - `inst_sram_rdata`=0, `data_sram_rdata`=0
  - `mem_req`=0, `mem_wr`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0
  - `stallreq`=0
- Fetch only, with zero-wait memory (cycles relative to the IDLE cycle, t0):

  | Cycle | State | Event | `stallreq` |
  |---|---|---|---|
  | t0 | IDLE | request latched | 1 |
  | t1 | I_REQ | addr_ok | 1 |
  | t2 | I_WAIT | data_ok | 1 |
  | t3 | DONE | — | 0 |
  | t4 | — | core consumes rdata | — |

  Minimum: 3 stall cycles.
- Load/store plus fetch: minimum 5 stall cycles. Each cycle that `addr_ok` or `data_ok` arrives late adds one stall cycle.
- A synchronous reset in any state returns to IDLE on the next edge and drops `mem_req`. A transaction already accepted by memory is abandoned; a `data_ok` that arrives afterwards is ignored.

## Test plan
- Fetch only, addr 0xBFC0_0000, zero-wait memory returning 0x2408_0001:
  - `stallreq` is high t0–t2 and low at t3.
  - `inst_sram_rdata`=0x2408_0001 from t3.
  - `data_sram_rdata` stays 0.
- Fetch 0xBFC0_0004 plus load 0x8000_0010:
  - The data request is issued first (`mem_wr`=0, `mem_wstrb`=0), then the fetch.
  - Both rdata registers are correct at DONE.
  - `stallreq` is high for exactly 5 cycles.
- Store `wen`=4'b0011, `wdata`=0x0000_BEEF, addr 0x8000_0020:
  - `mem_wr`=1, `mem_wstrb`=4'b0011, `mem_wdata`=0x0000_BEEF.
  - `data_sram_rdata` is unchanged after completion.
- Memory delays `addr_ok` by 3 cycles and `data_ok` by 2 cycles on a fetch:
  - `mem_req`, `mem_addr` and `mem_wr` stay stable throughout.
  - Total stall is 3+3+2 = 8 cycles.
- Reset asserted in D_WAIT, then a stray `data_ok`:
  - State returns to IDLE, rdata registers are 0, and the stray `data_ok` causes no capture.
  - `stallreq`=0 while `rst`.
- Back-to-back fetches 0x0 and 0x4:
  - The second request is latched in the IDLE cycle after DONE.
  - `inst_sram_rdata` holds the first word until the second `data_ok`.
